io_bus_arbiter: RTL and testbench

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_if.sv | 47 ++++
 rtl/io_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_io_bus_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/io_bus_if.sv
// rtl/io_bus_if.sv - two-requester IO bus interface between requesters, arbiter and IO manager
interface io_bus_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              io_ce;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_din;
    logic [DATA_W-1:0] io_dout;

    // arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  io_dout,
        output m0_gnt, m0_ack, m0_rdata,
        output m1_gnt, m1_ack, m1_rdata,
        output io_ce, io_we, io_addr, io_din
    );

    // requesters and IO manager side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output io_dout,
        input  m0_gnt, m0_ack, m0_rdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  io_ce, io_we, io_addr, io_din
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-requester IO bus arbiter, IDLE/ISSUE/DONE sequencer; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module io_bus_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    io_bus_if.slave  bus,
    output logic     busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;   // 1 = m1 won last
    logic              win_q, win_d;             // owner of the access in flight, 1 = m1
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic any_req;
    logic pick_m1;

    // Choose the winner among the current requests
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.m0_req && bus.m1_req) begin
            pick_m1 = ~last_gnt_q;
        end else begin
            pick_m1 = bus.m1_req;
        end
`else
        pick_m1 = bus.m1_req & ~bus.m0_req;
`endif
    end

    // Sequencer next-state: latch the winner in IDLE, capture read data leaving ISSUE, ack in DONE
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_gnt_d   = 1'b0;
        m1_gnt_d   = 1'b0;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_ISSUE;
                    win_d      = pick_m1;
                    last_gnt_d = pick_m1;
                    we_d       = pick_m1 ? bus.m1_we    : bus.m0_we;
                    addr_d     = pick_m1 ? bus.m1_addr  : bus.m0_addr;
                    wdata_d    = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                    m0_gnt_d   = ~pick_m1;
                    m1_gnt_d   = pick_m1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_DONE;
                if (!we_q) begin
                    if (win_q) begin
                        m1_rdata_d = bus.io_dout;
                    end else begin
                        m0_rdata_d = bus.io_dout;
                    end
                end
                m0_ack_d = ~win_q;
                m1_ack_d = win_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_gnt_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_gnt_q   <= m0_gnt_d;
            m1_gnt_q   <= m1_gnt_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Bus strobes only in ISSUE; address and data keep the latched values otherwise
    assign bus.io_ce    = (state_q == ST_ISSUE) & ~we_q;
    assign bus.io_we    = (state_q == ST_ISSUE) & we_q;
    assign bus.io_addr  = addr_q;
    assign bus.io_din   = wdata_q;
    assign bus.m0_gnt   = m0_gnt_q;
    assign bus.m1_gnt   = m1_gnt_q;
    assign bus.m0_ack   = m0_ack_q;
    assign bus.m1_ack   = m1_ack_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed self-checking bench for io_bus_arbiter
module tb_io_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_fail = 0;

    io_bus_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    io_bus_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] order;
    int         n_gnt;
    logic [3:0] exp_order;

    initial begin
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.io_dout = '0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_m0_gnt", bus.m0_gnt, 0);
        check("rst_io_ce", bus.io_ce, 0);
        check("rst_io_addr", bus.io_addr, 0);
        check("rst_m1_rdata", bus.m1_rdata, 0);
        tick();
        rst_n = 1;

        // m0 write
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 6'h03; bus.m0_wdata = 32'hDEADBEEF;
        tick();
        check("wr_m0_gnt", bus.m0_gnt, 1);
        check("wr_m1_gnt", bus.m1_gnt, 0);
        check("wr_io_we", bus.io_we, 1);
        check("wr_io_ce", bus.io_ce, 0);
        check("wr_io_addr", bus.io_addr, 6'h03);
        check("wr_io_din", bus.io_din, 32'hDEADBEEF);
        check("wr_busy", busy, 1);
        check("wr_early_ack", bus.m0_ack, 0);
        tick();
        check("wr_m0_ack", bus.m0_ack, 1);
        check("wr_gnt_off", bus.m0_gnt, 0);
        check("wr_done_we", bus.io_we, 0);
        bus.m0_req = 0;
        tick();
        check("wr_idle", busy, 0);
        check("wr_ack_off", bus.m0_ack, 0);
        check("wr_rdata_kept", bus.m0_rdata, 0);

        // m1 read
        bus.io_dout = 32'hDEADBEEF;
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 6'h03;
        tick();
        check("rd_m1_gnt", bus.m1_gnt, 1);
        check("rd_io_ce", bus.io_ce, 1);
        check("rd_io_we", bus.io_we, 0);
        tick();
        check("rd_m1_ack", bus.m1_ack, 1);
        check("rd_m1_rdata", bus.m1_rdata, 32'hDEADBEEF);
        check("rd_ce_off", bus.io_ce, 0);
        bus.m1_req = 0;
        bus.io_dout = 32'h12345678;
        tick();
        check("rd_rdata_held", bus.m1_rdata, 32'hDEADBEEF);

        // both requesters held for four accesses
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 6'h01;
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 6'h02;
        order = '0;
        n_gnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.m0_gnt && bus.m1_gnt) check("dual_gnt", 1, 0);
            if (bus.m0_ack && bus.m1_ack) check("dual_ack", 1, 0);
            if ((bus.m0_gnt || bus.m1_gnt) && n_gnt < 4) begin
                order[n_gnt] = bus.m1_gnt;
                n_gnt++;
            end
        end
        bus.m0_req = 0; bus.m1_req = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        check("arb_count", n_gnt, 4);
        check("arb_order", order, exp_order);
        tick(); tick();

        // LED write
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 6'h20; bus.m0_wdata = 32'h0000000F;
        tick();
        check("led_io_we", bus.io_we, 1);
        check("led_io_addr", bus.io_addr, 6'h20);
        check("led_io_din", bus.io_din, 32'h0000000F);
        tick();
        check("led_we_off", bus.io_we, 0);
        check("led_m0_ack", bus.m0_ack, 1);
        bus.m0_req = 0;
        tick();

        // reset during ISSUE
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 6'h05; bus.m1_wdata = 32'hAA;
        tick();
        check("rst_mid_busy_pre", busy, 1);
        rst_n = 0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_gnt", bus.m1_gnt, 0);
        check("rst_mid_io_we", bus.io_we, 0);
        check("rst_mid_io_addr", bus.io_addr, 0);
        check("rst_mid_io_din", bus.io_din, 0);
        check("rst_mid_rdata", bus.m1_rdata, 0);
        bus.m1_req = 0;
        tick();
        check("rst_mid_no_ack0", bus.m1_ack, 0);
        tick();
        check("rst_mid_no_ack1", bus.m1_ack, 0);
        rst_n = 1;
        bus.io_dout = 32'hCAFE0001;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 6'h07;
        tick();
        check("post_rst_gnt", bus.m0_gnt, 1);
        check("post_rst_ce", bus.io_ce, 1);
        tick();
        check("post_rst_ack", bus.m0_ack, 1);
        check("post_rst_rdata", bus.m0_rdata, 32'hCAFE0001);
        bus.m0_req = 0;
        tick();

        // request dropped after grant, inputs changed mid-access
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 6'h01; bus.m0_wdata = 32'h11;
        tick();
        check("drop_gnt", bus.m0_gnt, 1);
        bus.m0_req = 0; bus.m0_addr = 6'h02; bus.m0_wdata = 32'h22;
        check("drop_io_addr_issue", bus.io_addr, 6'h01);
        tick();
        check("drop_ack", bus.m0_ack, 1);
        check("drop_io_addr_done", bus.io_addr, 6'h01);
        check("drop_io_din_done", bus.io_din, 32'h11);
        tick();
        check("drop_idle", busy, 0);
        tick();
        check("drop_no_regrant", bus.m0_gnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
